// File: rtl/pll_lock_detector.sv
// ADPLL lock detector: samples phase error and DCO code on each synchronised
// reference-clock edge and reports lock, acquisition timeout and DCO saturation.
module pll_lock_detector #(
  parameter int ERROR_WIDTH     = 8,
  parameter int DCO_CC_WIDTH    = 5,
  parameter int LOCK_THRESH     = 2,
  parameter int LOCK_COUNT      = 16,
  parameter int UNLOCK_COUNT    = 4,
  parameter int TIMEOUT_SAMPLES = 1024,
  parameter int SAT_SAMPLES     = 8
) (
  input  logic                           fpga_clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic                           ref_clk_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_i,
  input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
  output logic                           sample_o,
  output logic                           in_window_o,
  output logic                           locked_o,
  output logic [1:0]                     lock_state_o,
  output logic                           timeout_o,
  output logic                           dco_sat_o
);

  // state    | meaning
  // IDLE     | detector disabled; counters and flags held clear
  // ACQUIRE  | counting consecutive in-window samples toward lock
  // LOCKED   | lock declared
  // HOLDOVER | lock kept while out-of-window samples accumulate
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
  localparam int SW = $clog2(SAT_SAMPLES + 1);

  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] BAD_MAX  = BW'(UNLOCK_COUNT);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_SAMPLES);
  localparam logic [SW-1:0] SAT_MAX  = SW'(SAT_SAMPLES);
  localparam logic [ERROR_WIDTH:0]    THRESH = (ERROR_WIDTH+1)'(LOCK_THRESH);
  localparam logic [DCO_CC_WIDTH-1:0] CC_HI  = {1'b0, {(DCO_CC_WIDTH-1){1'b1}}};
  localparam logic [DCO_CC_WIDTH-1:0] CC_LO  = {1'b1, {(DCO_CC_WIDTH-1){1'b0}}};

  state_t state, state_nxt;
  logic s1, s2, s3, st;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [BW-1:0] bad_cnt, bad_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [SW-1:0] sat_cnt, sat_nxt;
  logic timeout_nxt, in_window_nxt, dco_sat_nxt;
  logic signed [ERROR_WIDTH:0] err_ext;
  logic [ERROR_WIDTH:0] err_abs;
  logic in_win, extreme;

  assign st = s2 & ~s3;

  // One extra bit so the most negative error has a representable magnitude
  assign err_ext = {error_i[ERROR_WIDTH-1], error_i};
  assign err_abs = err_ext[ERROR_WIDTH] ? $unsigned(-err_ext) : $unsigned(err_ext);
  assign in_win  = (err_abs <= THRESH);
  assign extreme = ($unsigned(dco_cc_i) == CC_HI) || ($unsigned(dco_cc_i) == CC_LO);

  assign locked_o     = (state == LOCKED) || (state == HOLDOVER);
  assign lock_state_o = state;

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    good_nxt      = good_cnt;
    bad_nxt       = bad_cnt;
    tmo_nxt       = tmo_cnt;
    sat_nxt       = sat_cnt;
    timeout_nxt   = timeout_o;
    in_window_nxt = in_window_o;
    dco_sat_nxt   = dco_sat_o;
    if (!enable_i || state == IDLE) begin
      state_nxt     = enable_i ? ACQUIRE : IDLE;
      good_nxt      = '0;
      bad_nxt       = '0;
      tmo_nxt       = '0;
      sat_nxt       = '0;
      timeout_nxt   = 1'b0;
      in_window_nxt = 1'b0;
      dco_sat_nxt   = 1'b0;
    end else if (st) begin
      in_window_nxt = in_win;
      if (!extreme)                sat_nxt = '0;
      else if (sat_cnt != SAT_MAX) sat_nxt = sat_cnt + 1'b1;
      dco_sat_nxt = (sat_nxt == SAT_MAX);
      case (state)
        ACQUIRE: begin
          if (tmo_cnt != TMO_MAX) tmo_nxt = tmo_cnt + 1'b1;
          if (tmo_nxt == TMO_MAX) timeout_nxt = 1'b1;
          good_nxt = in_win ? good_cnt + 1'b1 : '0;
          // Lock entry wins over a timeout reached on the same sample
          if (good_nxt == GOOD_MAX) begin
            state_nxt   = LOCKED;
            good_nxt    = '0;
            tmo_nxt     = '0;
            timeout_nxt = 1'b0;
          end
        end
        LOCKED: begin
          if (!in_win) begin
            if (UNLOCK_COUNT == 1) begin
              state_nxt = ACQUIRE;
              good_nxt  = '0;
              tmo_nxt   = '0;
            end else begin
              state_nxt = HOLDOVER;
              bad_nxt   = BW'(1);
            end
          end
        end
        HOLDOVER: begin
          if (in_win) begin
            state_nxt   = LOCKED;
            bad_nxt     = '0;
            timeout_nxt = 1'b0;
          end else begin
            if (bad_cnt != BAD_MAX) bad_nxt = bad_cnt + 1'b1;
            if (bad_nxt == BAD_MAX) begin
              state_nxt = ACQUIRE;
              bad_nxt   = '0;
              good_nxt  = '0;
              tmo_nxt   = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      sample_o    <= 1'b0;
      in_window_o <= 1'b0;
      timeout_o   <= 1'b0;
      dco_sat_o   <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      tmo_cnt     <= '0;
      sat_cnt     <= '0;
    end else begin
      s1          <= ref_clk_i;
      s2          <= s1;
      s3          <= s2;
      sample_o    <= st;
      in_window_o <= in_window_nxt;
      timeout_o   <= timeout_nxt;
      dco_sat_o   <= dco_sat_nxt;
      good_cnt    <= good_nxt;
      bad_cnt     <= bad_nxt;
      tmo_cnt     <= tmo_nxt;
      sat_cnt     <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_pll_lock_detector.sv
// Bench for pll_lock_detector: directed scenarios plus random samples checked
// against a sample-level behavioural model of the lock rules.
module tb_pll_lock_detector;
  localparam int EW = 8;
  localparam int CW = 5;
  localparam int THRESH = 2;
  localparam int N_LOCK = 16;
  localparam int N_UNLOCK = 4;
  localparam int N_TMO = 1024;
  localparam int N_SAT = 8;

  logic fpga_clk_i, reset_i, enable_i, ref_clk_i;
  logic [EW-1:0] error_i;
  logic [CW-1:0] dco_cc_i;
  logic sample_o, in_window_o, locked_o, timeout_o, dco_sat_o;
  logic [1:0] lock_state_o;

  int checks = 0;
  int failures = 0;

  // model: phase 0=disabled 1=acquiring 2=locked 3=holdover
  int m_phase, m_good_run, m_bad_run, m_acq_samples, m_ext_run;
  bit m_timeout, m_inwin;

  pll_lock_detector dut (
    .fpga_clk_i(fpga_clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .ref_clk_i(ref_clk_i), .error_i(error_i), .dco_cc_i(dco_cc_i),
    .sample_o(sample_o), .in_window_o(in_window_o), .locked_o(locked_o),
    .lock_state_o(lock_state_o), .timeout_o(timeout_o), .dco_sat_o(dco_sat_o)
  );

  initial fpga_clk_i = 1'b0;
  always #5 fpga_clk_i = ~fpga_clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic void model_disable();
    m_phase = 0; m_good_run = 0; m_bad_run = 0; m_acq_samples = 0;
    m_ext_run = 0; m_timeout = 0; m_inwin = 0;
  endfunction

  function automatic void model_sample(input int err, input int cc);
    int mag;
    mag = (err < 0) ? -err : err;
    m_inwin = (mag <= THRESH);
    if (cc == 15 || cc == -16) m_ext_run = (m_ext_run < N_SAT) ? m_ext_run + 1 : N_SAT;
    else m_ext_run = 0;
    if (m_phase == 1) begin
      m_acq_samples++;
      if (m_acq_samples >= N_TMO) m_timeout = 1;
      m_good_run = m_inwin ? m_good_run + 1 : 0;
      if (m_good_run == N_LOCK) begin
        m_phase = 2; m_good_run = 0; m_timeout = 0;
      end
    end else if (m_phase == 2) begin
      if (!m_inwin) begin
        m_phase = 3; m_bad_run = 1;
      end
    end else if (m_phase == 3) begin
      if (m_inwin) begin
        m_phase = 2; m_bad_run = 0;
      end else begin
        m_bad_run++;
        if (m_bad_run >= N_UNLOCK) begin
          m_phase = 1; m_bad_run = 0; m_good_run = 0; m_acq_samples = 0;
        end
      end
    end
  endfunction

  function automatic logic [6:0] model_out(input bit smp);
    logic [1:0] ph;
    ph = 2'(m_phase);
    return {smp, m_inwin, (m_phase >= 2), ph, m_timeout, (m_ext_run >= N_SAT)};
  endfunction

  function automatic logic [6:0] dut_out();
    return {sample_o, in_window_o, locked_o, lock_state_o, timeout_o, dco_sat_o};
  endfunction

  function automatic int rand_good();
    return int'($urandom_range(0, 4)) - 2;
  endfunction

  // One reference edge: drive data, raise ref, sample just after the evaluation edge
  task automatic do_sample(input int err, input int cc, output logic [6:0] obs,
                           output logic [6:0] exp);
    @(negedge fpga_clk_i);
    error_i = EW'(err);
    dco_cc_i = CW'(cc);
    ref_clk_i = 1'b1;
    repeat (3) @(posedge fpga_clk_i);
    #1;
    obs = dut_out();
    model_sample(err, cc);
    exp = model_out(1'b1);
    ref_clk_i = 1'b0;
    repeat (3) @(posedge fpga_clk_i);
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    reset_i = 1'b0; enable_i = 1'b0; ref_clk_i = 1'b0;
    error_i = '0; dco_cc_i = '0;
    model_disable();
    for (int i = 0; i < 6; i++) begin
      @(negedge fpga_clk_i);
      ref_clk_i = ~ref_clk_i;
      #1;
      checks++;
      if (dut_out() !== 7'b0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", i, dut_out(), 7'b0);
      end
    end
    @(negedge fpga_clk_i);
    ref_clk_i = 1'b0;
    reset_i = 1'b1;
    enable_i = 1'b1;
    #1;
    checks++;
    if (lock_state_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_release_idle: got %0d want 0", lock_state_o);
    end
    @(posedge fpga_clk_i);
    #1;
    m_phase = 1;
    exp = model_out(1'b0);
    checks++;
    if (dut_out() !== exp || lock_state_o !== 2'd1) begin
      failures++;
      $display("FAIL reset_to_acquire: got %b want %b", dut_out(), exp);
    end
  endtask

  task automatic test_lock_acquire();
    logic [6:0] obs, exp;
    for (int i = 0; i < 15; i++) begin
      do_sample((i == 14) ? 3 : rand_good(), 0, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL acquire_broken sample %0d: got %b want %b", i, obs, exp);
      end
    end
    for (int i = 0; i < 16; i++) begin
      do_sample((i % 2 == 0) ? 2 : -2, 0, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL acquire_run sample %0d: got %b want %b", i, obs, exp);
      end
      if (i == 14 || i == 15) begin
        checks++;
        if (obs[4:2] !== ((i == 15) ? 3'b110 : 3'b001)) begin
          failures++;
          $display("FAIL acquire_lock_point sample %0d: got locked/state %b want %b",
                   i, obs[4:2], (i == 15) ? 3'b110 : 3'b001);
        end
      end
    end
  endtask

  task automatic test_hysteresis();
    logic [6:0] obs, exp;
    for (int i = 0; i < 4; i++) begin
      do_sample((i < 3) ? -5 : 0, 0, obs, exp);
      checks++;
      if (obs !== exp || obs[4:2] !== ((i < 3) ? 3'b111 : 3'b110)) begin
        failures++;
        $display("FAIL holdover_return sample %0d: got %b want %b", i, obs, exp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_sample(-5, 0, obs, exp);
      checks++;
      if (obs !== exp || obs[4:2] !== ((i < 3) ? 3'b111 : 3'b001)) begin
        failures++;
        $display("FAIL holdover_unlock sample %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] obs, exp;
    for (int i = 0; i < N_TMO + 4; i++) begin
      do_sample(-128, 0, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL timeout_run sample %0d: got %b want %b", i, obs, exp);
      end
      if (i == N_TMO - 2 || i == N_TMO - 1) begin
        checks++;
        if (obs[1] !== (i == N_TMO - 1) || obs[5] !== 1'b0) begin
          failures++;
          $display("FAIL timeout_edge sample %0d: got timeout=%b want %b", i, obs[1],
                   i == N_TMO - 1);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      do_sample(1, 0, obs, exp);
      checks++;
      if (obs !== exp || obs[1] !== (i < 15)) begin
        failures++;
        $display("FAIL timeout_clear sample %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_dco_sat();
    logic [6:0] obs, exp;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 9; i++) begin
        do_sample(0, (i == 8) ? 0 : ((pass == 0) ? 15 : -16), obs, exp);
        checks++;
        if (obs !== exp || obs[0] !== (i == 7)) begin
          failures++;
          $display("FAIL dco_sat pass %0d sample %0d: got %b want %b", pass, i, obs, exp);
        end
      end
    end
  endtask

  task automatic test_enable_drop_holdover();
    logic [6:0] obs, exp;
    for (int i = 0; i < 9; i++) begin
      do_sample((i == 8) ? -5 : 0, 15, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL drop_setup sample %0d: got %b want %b", i, obs, exp);
      end
    end
    checks++;
    if (obs !== 7'b1011101) begin
      failures++;
      $display("FAIL drop_precondition: got %b want %b", obs, 7'b1011101);
    end
    @(negedge fpga_clk_i);
    error_i = EW'(-5);
    dco_cc_i = CW'(15);
    ref_clk_i = 1'b1;
    repeat (2) @(posedge fpga_clk_i);
    @(negedge fpga_clk_i);
    enable_i = 1'b0;
    @(posedge fpga_clk_i);
    #1;
    model_disable();
    exp = model_out(1'b1);
    checks++;
    if (dut_out() !== exp) begin
      failures++;
      $display("FAIL drop_coincident: got %b want %b", dut_out(), exp);
    end
    ref_clk_i = 1'b0;
    repeat (3) @(posedge fpga_clk_i);
    @(negedge fpga_clk_i);
    enable_i = 1'b1;
    @(posedge fpga_clk_i);
    #1;
    m_phase = 1;
    exp = model_out(1'b0);
    checks++;
    if (dut_out() !== exp) begin
      failures++;
      $display("FAIL drop_reenable: got %b want %b", dut_out(), exp);
    end
  endtask

  task automatic test_random();
    logic [6:0] obs, exp;
    int err, cc;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        @(negedge fpga_clk_i);
        enable_i = 1'b0;
        @(posedge fpga_clk_i);
        #1;
        model_disable();
        exp = model_out(1'b0);
        checks++;
        if (dut_out() !== exp) begin
          failures++;
          $display("FAIL random_disable step %0d: got %b want %b", i, dut_out(), exp);
        end
        @(negedge fpga_clk_i);
        enable_i = 1'b1;
        @(posedge fpga_clk_i);
        #1;
        m_phase = 1;
      end
      err = ($urandom_range(0, 99) < 93) ? rand_good() : int'($urandom_range(0, 255)) - 128;
      cc = ($urandom_range(0, 99) < 40) ? (($urandom_range(0, 1) == 1) ? 15 : -16)
                                        : int'($urandom_range(0, 31)) - 16;
      do_sample(err, cc, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random step %0d err=%0d cc=%0d: got %b want %b", i, err, cc, obs, exp);
      end
      repeat ($urandom_range(0, 2)) @(posedge fpga_clk_i);
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] obs, exp;
    @(negedge fpga_clk_i);
    enable_i = 1'b0;
    @(negedge fpga_clk_i);
    enable_i = 1'b1;
    @(posedge fpga_clk_i);
    #1;
    model_disable();
    m_phase = 1;
    for (int i = 0; i < 16; i++) do_sample(rand_good(), 0, obs, exp);
    checks++;
    if (obs !== exp || locked_o !== 1'b1) begin
      failures++;
      $display("FAIL async_setup: got %b want %b", obs, exp);
    end
    @(posedge fpga_clk_i);
    #3;
    reset_i = 1'b0;
    #1;
    model_disable();
    exp = model_out(1'b0);
    checks++;
    if (dut_out() !== exp) begin
      failures++;
      $display("FAIL async_reset: got %b want %b", dut_out(), exp);
    end
    repeat (2) @(posedge fpga_clk_i);
    reset_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_hysteresis();
    test_timeout();
    test_dco_sat();
    test_enable_drop_holdover();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
